// File: rtl/sisc_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// sisc_prog_loader_pkg : state encodings and frame field widths for the loader
// Rev 1.0
// ============================================================================
package sisc_prog_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int CNT_W      = 16;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_CNT_HI = 3'd0;
    localparam state_t ST_CNT_LO = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_WRITE  = 3'd3;
    localparam state_t ST_CSUM   = 3'd4;
    localparam state_t ST_RUN    = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

    // States in which the loader consumes stream bytes.
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sisc_word_packer.sv
`default_nettype none
// ============================================================================
// sisc_word_packer : packs MSB-first bytes into 32-bit words, pulses word_rdy
// Rev 1.0
// ============================================================================
module sisc_word_packer
    import sisc_prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_f,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_rdy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    // Only the first three bytes need storage; the fourth completes the word on the fly.
    logic [WORD_W-BYTE_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;

    always_comb begin
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        if (shift_en) begin
            shreg_d    = {shreg_q[WORD_W-2*BYTE_W-1:0], byte_in};
            byte_idx_d = byte_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            shreg_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign word     = {shreg_q, byte_in};
    assign word_rdy = shift_en && (byte_idx_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/sisc_prog_loader.sv
`default_nettype none
// ============================================================================
// sisc_prog_loader : streams a checksummed program image into instruction
//                    memory and holds the SISC core in reset until verified
// Rev 1.0
// ============================================================================
module sisc_prog_loader
    import sisc_prog_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
    input  logic              clk,
    input  logic              rst_f,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_rst_f,
    output logic              done,
    output logic              err
);

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_W) - {{(33-ADDR_W){1'b0}}, BASE_ADDR};

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]    words_left_q, words_left_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                in_ready_q, in_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
    logic                cpu_rst_f_q, cpu_rst_f_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [CNT_W-1:0]    cnt_w;
    logic                overflow;
    logic [WORD_W-1:0]   packed_word;
    logic                word_rdy;

    assign accept   = in_valid && in_ready_q;
    assign cnt_w    = {cnt_hi_q, in_data};
    assign overflow = {{(33-CNT_W){1'b0}}, cnt_w} > MAX_WORDS;

    sisc_word_packer u_packer (
        .clk      (clk),
        .rst_f    (rst_f),
        .shift_en (accept && (state_q == ST_DATA)),
        .byte_in  (in_data),
        .word     (packed_word),
        .word_rdy (word_rdy)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_CNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CNT_HI: if (accept) state_d = ST_CNT_LO;
            ST_CNT_LO: begin
                if (accept) begin
                    if (overflow)          state_d = ST_ERROR;
                    else if (cnt_w == '0)  state_d = ST_CSUM;
                    else                   state_d = ST_DATA;
                end
            end
            ST_DATA:   if (word_rdy) state_d = ST_WRITE;
            ST_WRITE:  state_d = (words_left_q == '0) ? ST_CSUM : ST_DATA;
            ST_CSUM:   if (accept) state_d = (in_data == csum_q) ? ST_RUN : ST_ERROR;
            ST_RUN:    state_d = ST_RUN;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_CNT_HI;
        endcase
    end

    always_comb begin
        cnt_hi_d     = cnt_hi_q;
        words_left_d = words_left_q;
        csum_d       = csum_q;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;

        if (accept && (state_q == ST_CNT_HI)) cnt_hi_d = in_data;
        if (accept && (state_q == ST_CNT_LO)) words_left_d = cnt_w;
        if (word_rdy) begin
            words_left_d = words_left_q - CNT_W'(1);
            im_wdata_d   = packed_word;
        end
        // The CSUM byte itself is compared against, never folded in.
        if (accept && (state_q != ST_CSUM)) csum_d = csum_q ^ in_data;
        if (state_q == ST_WRITE) im_addr_d = im_addr_q + ADDR_W'(1);

        // Registered outputs follow the state being entered.
        in_ready_d  = accepts_bytes(state_d);
        im_we_d     = (state_d == ST_WRITE);
        cpu_rst_f_d = (state_d == ST_RUN);
        done_d      = (state_d == ST_RUN);
        err_d       = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt_hi_q     <= '0;
            words_left_q <= '0;
            csum_q       <= '0;
            in_ready_q   <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= BASE_ADDR;
            im_wdata_q   <= '0;
            cpu_rst_f_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_hi_q     <= cnt_hi_d;
            words_left_q <= words_left_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            cpu_rst_f_q  <= cpu_rst_f_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_rst_f = cpu_rst_f_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sisc_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_sisc_prog_loader : directed self-checking bench for the program loader
// Rev 1.0
// ============================================================================
module tb_sisc_prog_loader;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, im_we, cpu_rst_f, done, err;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;

    logic [7:0]  ovf_in_data = '0;
    logic        ovf_in_valid = 1'b0;
    logic        ovf_in_ready, ovf_im_we, ovf_cpu_rst_f, ovf_done, ovf_err;
    logic [3:0]  ovf_im_addr;
    logic [31:0] ovf_im_wdata;

    int checks = 0;
    int errors = 0;

    int          wr_cnt = 0;
    int          rdy_in_write = 0;
    int          we_double = 0;
    int          ovf_we_cnt = 0;
    logic        prev_we = 1'b0;
    logic [15:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [7:0]  frame [$];

    always #5 clk = ~clk;

    sisc_prog_loader #(.ADDR_W(16)) dut (
        .clk(clk), .rst_f(rst_f), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst_f(cpu_rst_f), .done(done), .err(err)
    );

    sisc_prog_loader #(.ADDR_W(4)) dut_ovf (
        .clk(clk), .rst_f(rst_f), .in_data(ovf_in_data), .in_valid(ovf_in_valid),
        .in_ready(ovf_in_ready), .im_we(ovf_im_we), .im_addr(ovf_im_addr), .im_wdata(ovf_im_wdata),
        .cpu_rst_f(ovf_cpu_rst_f), .done(ovf_done), .err(ovf_err)
    );

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        prev_we <= im_we;
        if (im_we === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= im_addr;
                wr_data[wr_cnt] <= im_wdata;
            end
            wr_cnt <= wr_cnt + 1;
            if (in_ready === 1'b1) rdy_in_write <= rdy_in_write + 1;
            if (prev_we === 1'b1) we_double <= we_double + 1;
        end
        if (ovf_im_we === 1'b1) ovf_we_cnt <= ovf_we_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one byte and holds it until the rising edge that transfers it.
    task automatic send_byte(input logic [7:0] b, input bit to_ovf);
        int   waited;
        logic rdy;
        waited = 0;
        if (to_ovf) begin ovf_in_data = b; ovf_in_valid = 1'b1; end
        else        begin in_data = b;     in_valid = 1'b1;     end
        rdy = to_ovf ? ovf_in_ready : in_ready;
        while (rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
            rdy = to_ovf ? ovf_in_ready : in_ready;
        end
        if (rdy !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", rdy, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ovf_in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) begin
            if (gaps) idle($urandom_range(0, 3));
            send_byte(frame[i], 1'b0);
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        ovf_in_valid = 1'b0;
        rst_f = 1'b0;
        idle(2);
        rst_f = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        rst_f = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        idle(3);
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (im_we !== 1'b0)     begin errors++; $display("FAIL reset_im_we: got %b want 0", im_we); end
        checks++; if (im_addr !== 16'h0)  begin errors++; $display("FAIL reset_im_addr: got %h want 0000", im_addr); end
        checks++; if (im_wdata !== 32'h0) begin errors++; $display("FAIL reset_im_wdata: got %h want 0", im_wdata); end
        checks++; if (cpu_rst_f !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_f: got %b want 0", cpu_rst_f); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        in_valid = 1'b0;
        rst_f = 1'b1;
        idle(1);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    // Checksums below are the XOR of every preceding frame byte (0x28 for this image).
    task automatic test_two_word();
        int base;
        apply_reset();
        base = wr_cnt;
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
        checks++; if (im_we !== 1'b1)           begin errors++; $display("FAIL w0_latency_we: got %b want 1", im_we); end
        checks++; if (im_addr !== 16'h0000)     begin errors++; $display("FAIL w0_addr: got %h want 0000", im_addr); end
        checks++; if (im_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL w0_data: got %h want DEADBEEF", im_wdata); end
        checks++; if (in_ready !== 1'b0)        begin errors++; $display("FAIL w0_ready_in_write: got %b want 0", in_ready); end
        send_byte(8'h12, 1'b0);
        checks++; if (im_addr !== 16'h0001)     begin errors++; $display("FAIL addr_incr: got %h want 0001", im_addr); end
        send_byte(8'h34, 1'b0); send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
        checks++; if (im_wdata !== 32'h12345678) begin errors++; $display("FAIL w1_data: got %h want 12345678", im_wdata); end
        checks++; if (done !== 1'b0)            begin errors++; $display("FAIL done_early: got %b want 0", done); end
        send_byte(8'h28, 1'b0);
        checks++; if (done !== 1'b1)            begin errors++; $display("FAIL two_word_done: got %b want 1", done); end
        checks++; if (cpu_rst_f !== 1'b1)       begin errors++; $display("FAIL two_word_cpu_rst_f: got %b want 1", cpu_rst_f); end
        checks++; if (err !== 1'b0)             begin errors++; $display("FAIL two_word_err: got %b want 0", err); end
        idle(3);
        checks++; if (wr_cnt - base !== 2)      begin errors++; $display("FAIL two_word_count: got %0d want 2", wr_cnt - base); end
        checks++; if (wr_addr[base+1] !== 16'h0001 || wr_data[base+1] !== 32'h12345678)
            begin errors++; $display("FAIL two_word_log1: got %h/%h want 0001/12345678", wr_addr[base+1], wr_data[base+1]); end
        checks++; if (in_ready !== 1'b0)        begin errors++; $display("FAIL run_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_bad_csum();
        apply_reset();
        frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7A};
        send_frame(1'b0);
        checks++; if (err !== 1'b1)       begin errors++; $display("FAIL bad_csum_err: got %b want 1", err); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL bad_csum_done: got %b want 0", done); end
        checks++; if (cpu_rst_f !== 1'b0) begin errors++; $display("FAIL bad_csum_cpu_rst_f: got %b want 0", cpu_rst_f); end
        in_valid = 1'b1; in_data = 8'h28;
        idle(4);
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL err_sticky: got err=%b ready=%b done=%b want 1/0/0", err, in_ready, done); end
    endtask

    task automatic test_zero_count();
        int base;
        apply_reset();
        base = wr_cnt;
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        checks++; if (done !== 1'b1 || cpu_rst_f !== 1'b1)
            begin errors++; $display("FAIL zero_done: got done=%b cpu_rst_f=%b want 1/1", done, cpu_rst_f); end
        idle(2);
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_cnt - base); end
    endtask

    task automatic test_back_to_back_gaps();
        int base, rdy0, dbl0;
        apply_reset();
        base = wr_cnt; rdy0 = rdy_in_write; dbl0 = we_double;
        frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
        send_frame(1'b1);
        checks++; if (done !== 1'b1 || err !== 1'b0)
            begin errors++; $display("FAIL gaps_done: got done=%b err=%b want 1/0", done, err); end
        idle(2);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL gaps_count: got %0d want 2", wr_cnt - base); end
        checks++; if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 32'hDEADBEEF)
            begin errors++; $display("FAIL gaps_log0: got %h/%h want 0000/DEADBEEF", wr_addr[base], wr_data[base]); end
        checks++; if (wr_addr[base+1] !== 16'h0001 || wr_data[base+1] !== 32'h12345678)
            begin errors++; $display("FAIL gaps_log1: got %h/%h want 0001/12345678", wr_addr[base+1], wr_data[base+1]); end
        checks++; if (rdy_in_write !== rdy0) begin errors++; $display("FAIL ready_in_write: got %0d want %0d", rdy_in_write, rdy0); end
        checks++; if (we_double !== dbl0)    begin errors++; $display("FAIL we_pulse_width: got %0d want %0d", we_double, dbl0); end
    endtask

    task automatic test_reset_mid_load();
        int base;
        apply_reset();
        frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
        send_frame(1'b0);
        checks++; if (cpu_rst_f !== 1'b0) begin errors++; $display("FAIL midload_cpu_rst_f: got %b want 0", cpu_rst_f); end
        rst_f = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || im_addr !== 16'h0 || im_wdata !== 32'h0 || cpu_rst_f !== 1'b0)
            begin errors++; $display("FAIL async_reset: got ready=%b addr=%h data=%h cpu=%b want 0/0000/0/0", in_ready, im_addr, im_wdata, cpu_rst_f); end
        idle(2);
        rst_f = 1'b1;
        idle(2);
        base = wr_cnt;
        frame = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC8};
        send_frame(1'b0);
        checks++; if (done !== 1'b1 || err !== 1'b0)
            begin errors++; $display("FAIL reload_done: got done=%b err=%b want 1/0", done, err); end
        idle(2);
        checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL reload_count: got %0d want 1", wr_cnt - base); end
        checks++; if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 32'hCAFEF00D)
            begin errors++; $display("FAIL reload_log: got %h/%h want 0000/CAFEF00D", wr_addr[base], wr_data[base]); end
    endtask

    task automatic test_overflow();
        int w0;
        apply_reset();
        w0 = ovf_we_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        checks++; if (ovf_err !== 1'b1)       begin errors++; $display("FAIL ovf_err: got %b want 1", ovf_err); end
        checks++; if (ovf_in_ready !== 1'b0 || ovf_done !== 1'b0 || ovf_cpu_rst_f !== 1'b0)
            begin errors++; $display("FAIL ovf_outputs: got ready=%b done=%b cpu=%b want 0/0/0", ovf_in_ready, ovf_done, ovf_cpu_rst_f); end
        idle(4);
        checks++; if (ovf_we_cnt !== w0 || ovf_im_addr !== 4'h0 || ovf_im_wdata !== 32'h0)
            begin errors++; $display("FAIL ovf_no_write: got we=%0d addr=%h data=%h want %0d/0/0", ovf_we_cnt, ovf_im_addr, ovf_im_wdata, w0); end
        // N=16 exactly fills a 16-word memory and must be accepted.
        apply_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        checks++; if (ovf_err !== 1'b0 || ovf_in_ready !== 1'b1)
            begin errors++; $display("FAIL ovf_boundary: got err=%b ready=%b want 0/1", ovf_err, ovf_in_ready); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_csum();
        test_zero_count();
        test_back_to_back_gaps();
        test_reset_mid_load();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
